// File: rtl/msg_block_assembler.sv
// Byte-serial message collector: packs a valid/ready byte stream into one
// 256-bit block {length[7:0], message[247:0]} for the zero-padding stage.
module msg_block_assembler #(
  parameter int unsigned MAX_BYTES = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_nbits,
  output logic         in_ready,
  output logic [255:0] plainText,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MSG_W  = 248;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BLK_W  = MSG_W + LEN_W;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned NB_W   = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   nextCnt;
  logic [MSG_W-1:0]   buffer;
  logic [MSG_W-1:0]   nextBuf;
  logic [MSG_W-1:0]   byteBuf;
  logic [BLK_W-1:0]   nextPlain;
  logic               nextOutValid;
  logic               nextOverflow;
  logic               nextInReady;
  logic [NB_W-1:0]    nb;
  logic [LEN_W-1:0]   msgLen;
  logic               lastSlot;

  // State and registered outputs; reset discards any partial message.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      buffer    <= '0;
      plainText <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      buffer    <= nextBuf;
      plainText <= nextPlain;
      out_valid <= nextOutValid;
      overflow  <= nextOverflow;
      in_ready  <= nextInReady;
    end
  end

  // Next-state, buffer update and block assembly.
  always_comb begin
    nextState    = state;
    nextCnt      = cnt;
    nextBuf      = buffer;
    nextPlain    = plainText;
    nextOutValid = out_valid;
    nextOverflow = overflow;
    nextInReady  = in_ready;

    // Buffer with the incoming byte dropped into the current slot; slots at
    // or above MAX_BYTES are never written, so they stay zero.
    byteBuf = buffer;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (cnt == CNT_W'(i)) begin
        byteBuf[BYTE_W*i +: BYTE_W] = in_data;
      end
    end

    // Forced closes (no in_last) always count a full final byte.
    nb       = (in_last && (in_nbits != 3'd0)) ? NB_W'(in_nbits) : NB_W'(8);
    msgLen   = LEN_W'({cnt, 3'b000}) + LEN_W'(nb);
    lastSlot = (cnt == CNT_W'(MAX_BYTES - 1));

    case (state)
      COLLECT: begin
        nextInReady  = 1'b1;
        nextOutValid = 1'b0;
        if (in_valid && in_ready) begin
          nextBuf = byteBuf;
          if (in_last || lastSlot) begin
            nextState    = HOLD;
            nextCnt      = '0;
            nextPlain    = {msgLen, byteBuf};
            nextOutValid = 1'b1;
            nextOverflow = !in_last;
            nextInReady  = 1'b0;
          end else begin
            nextCnt = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        nextInReady = 1'b0;
        if (out_ready) begin
          nextState    = COLLECT;
          nextCnt      = '0;
          nextBuf      = '0;
          nextPlain    = '0;
          nextOutValid = 1'b0;
          nextOverflow = 1'b0;
          nextInReady  = 1'b1;
        end
      end
      default: begin
        nextState = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_msg_block_assembler.sv
// Scoreboard bench for msg_block_assembler: a byte-level model queues the
// expected block on every close, and a monitor pops it when a block transfers.
module tb_msg_block_assembler;

  localparam int unsigned MAX_BYTES = 31;

  typedef struct {
    logic [255:0] blk;
    logic         ovf;
  } expT;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_nbits;
  logic         in_ready;
  logic [255:0] plainText;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;

  int testsRun;
  int testsFailed;

  expT          expQ[$];
  logic [247:0] modelBuf;
  int           modelCnt;

  msg_block_assembler #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_nbits  (in_nbits),
    .in_ready  (in_ready),
    .plainText (plainText),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted byte; pushes the block on close.
  task automatic modelByte(input logic [7:0] d, input logic last, input logic [2:0] nbits);
    int  nbv;
    expT e;
    modelBuf[8*modelCnt +: 8] = d;
    if (last || modelCnt == int'(MAX_BYTES) - 1) begin
      nbv   = (last && nbits != 3'd0) ? int'(nbits) : 8;
      e.blk = {8'(8*modelCnt + nbv), modelBuf};
      e.ovf = !last;
      expQ.push_back(e);
      modelBuf = '0;
      modelCnt = 0;
    end else begin
      modelCnt++;
    end
  endtask

  // Drive one byte, wait for it to be accepted, then check out_valid latency.
  task automatic sendByte(input logic [7:0] d, input logic last, input logic [2:0] nbits);
    logic rdy;
    int   waitCycles;
    bit   closes;
    closes     = last || (modelCnt == int'(MAX_BYTES) - 1);
    in_data    = d;
    in_last    = last;
    in_nbits   = nbits;
    in_valid   = 1'b1;
    waitCycles = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      waitCycles++;
    end while (!rdy && waitCycles < 100);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_nbits = 3'd0;
    if (!rdy) begin
      checkEq("inReadyTimeout", 256'(rdy), 256'(1));
      return;
    end
    modelByte(d, last, nbits);
    if (closes) begin
      @(negedge clk);
      checkEq("outValidLatency", 256'(out_valid), 256'(1));
      checkEq("inReadyInHold", 256'(in_ready), 256'(0));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every transferred block against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkEq("unexpectedBlock", plainText, 256'(0));
      end else begin
        expT e;
        e = expQ.pop_front();
        checkEq("blockData", plainText, e.blk);
        checkEq("blockOverflow", 256'(overflow), 256'(e.ovf));
      end
    end
  end

  initial begin
    logic [255:0] held;
    testsRun    = 0;
    testsFailed = 0;
    modelBuf    = '0;
    modelCnt    = 0;
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_nbits    = '0;
    out_ready   = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rstInReady", 256'(in_ready), 256'(0));
    checkEq("rstOutValid", 256'(out_valid), 256'(0));
    checkEq("rstPlainText", plainText, 256'(0));
    checkEq("rstOverflow", 256'(overflow), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkEq("inReadyAfterRst", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;

    // Single full byte.
    sendByte(8'hA5, 1'b1, 3'd0);

    // Three bytes with a 4-bit tail, held under backpressure.
    out_ready = 1'b0;
    sendByte(8'h11, 1'b0, 3'd0);
    sendByte(8'h22, 1'b0, 3'd0);
    sendByte(8'h0F, 1'b1, 3'd4);
    @(negedge clk);
    held = plainText;
    checkEq("tailBytes", 256'(held[23:0]), 256'(24'h0F2211));
    checkEq("tailLength", 256'(held[255:248]), 256'(20));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("bpInReady", 256'(in_ready), 256'(0));
      checkEq("bpStable", plainText, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkEq("relOutValid", 256'(out_valid), 256'(0));
    checkEq("relInReady", 256'(in_ready), 256'(1));
    checkEq("relPlainText", plainText, 256'(0));
    @(posedge clk);
    #1;

    // Next message after backpressure must start from a clear buffer.
    sendByte(8'h3C, 1'b1, 3'd1);

    // Overflow: 31 full bytes with no last, then the 32nd opens a new block.
    for (int i = 0; i < int'(MAX_BYTES); i++) sendByte(8'hFF, 1'b0, 3'd0);
    sendByte(8'h5A, 1'b1, 3'd0);

    // Full-length message closed by in_last on the final slot.
    for (int i = 0; i < int'(MAX_BYTES) - 1; i++) sendByte(8'(i + 1), 1'b0, 3'd0);
    sendByte(8'hE7, 1'b1, 3'd3);

    // Reset in the middle of a message discards the partial bytes.
    sendByte(8'hDE, 1'b0, 3'd0);
    sendByte(8'hAD, 1'b0, 3'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkEq("midRstInReady", 256'(in_ready), 256'(0));
    modelBuf = '0;
    modelCnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sendByte(8'h01, 1'b1, 3'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checkEq("scoreboardDrain", 256'(expQ.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/msg_block_assembler.md
Name: msg_block_assembler

Overview:
Upstream feeder for the zero-padding stage. Collects a byte-serial message from a valid/ready stream and packs it into one 256-bit plainText block. Message bits go LSB-first from bit 0. The bit length of the message goes in plainText[255:248]. The padding stage that consumes this block clears everything above the length.

Parameters:
MAX_BYTES, 31, maximum message bytes per block; legal range 1..31, so that 8*MAX_BYTES <= 248.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  synchronous active-low reset.
in_data  input  8  message byte.
in_valid  input  1  in_data is valid this cycle.
in_last  input  1  with in_valid: this is the final byte of the message.
in_nbits  input  3  with in_last: number of valid bits in the final byte, counted from bit 0; 0 means 8.
in_ready  output  1  assembler can accept a byte.
plainText  output  256  assembled block: [247:0] message, [255:248] length in bits.
out_valid  output  1  plainText is valid and stable.
out_ready  input  1  downstream accepts the block.
overflow  output  1  block was closed because MAX_BYTES was reached without in_last; valid while out_valid is high.

Behaviour:
- Handshakes:
  - A byte transfers when in_valid && in_ready on a rising clk edge.
  - A block transfers when out_valid && out_ready.
- Reset, when rst_n=0 at a clock edge:
  - state=COLLECT, byte counter cnt=0, internal buffer=0.
  - plainText=0, out_valid=0, overflow=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after rst_n is released.
  - Reset in the middle of a message discards all partial data.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - On each accepted byte, in_data is written to buffer[8*cnt+7 : 8*cnt] and cnt increments.
  - The message closes if in_last=1, or if cnt==MAX_BYTES-1 (the byte just accepted fills the last slot).
  - On close, length[7:0] = 8*cnt_old + nb, where cnt_old is the count before this byte and nb = (in_nbits==0) ? 8 : in_nbits.
  - When the close is forced by MAX_BYTES with in_last=0: nb=8 and overflow is set to 1. Following bytes start a new message.
  - When MAX_BYTES is reached with in_last=1: overflow=0.
  - On close, next state is HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - plainText = {length, buffer[247:0]}; plainText and overflow are held constant.
  - On out_ready=1 the block transfers. Next cycle: state=COLLECT, cnt=0, buffer cleared to 0, overflow=0, plainText=0, out_valid=0.
- Latency:
  - out_valid rises in the cycle after the closing byte is accepted.
  - After the block transfers, in_ready returns 1 in the next cycle. This is one bubble cycle per block; no byte is accepted while in HOLD.
- Data rules:
  - Bits of the final byte above nb are stored raw. Cleaning them is the padding stage's job.
  - Unused byte slots read 0, because the buffer is cleared at the start of each message.
  - Bit positions from 8*MAX_BYTES to 247 are always 0.
- Edge cases:
  - A zero-length message cannot be expressed; the minimum length is 1 bit (one byte with in_nbits=1).
  - in_last and in_nbits are ignored when in_valid=0. in_nbits is ignored when in_last=0.
  - An in_valid pulse while in HOLD is not accepted (in_ready=0). The upstream source must hold the byte until in_ready rises.
  - out_ready asserted in COLLECT has no effect.

Test Plan:
- Reset then single byte: rst_n low 2 cycles, then send 0xA5 with in_last=1, in_nbits=0 -> next cycle out_valid=1, plainText[7:0]=0xA5, [255:248]=8, all other bits 0, overflow=0.
- Three bytes with partial tail: send 0x11, 0x22, 0x0F with in_last and in_nbits=4 -> plainText[23:0]=0x0F2211, length=20, overflow=0.
- Backpressure: after close, hold out_ready=0 for 5 cycles -> in_ready=0 and plainText stable; drive out_ready=1 -> out_valid=0 and in_ready=1 next cycle; the next message starts with a cleared buffer.
- Overflow: send 31 bytes of 0xFF with in_last=0 -> out_valid=1, length=248, plainText[247:0] all ones, overflow=1; the 32nd byte becomes byte 0 of the next block.
- Full message with last: 31 bytes, in_last on byte 31 with in_nbits=3 -> length=243, overflow=0.
- Reset mid-message: send 0xDE, 0xAD, assert rst_n=0 for 1 cycle, then send 0x01 with in_last=1 -> length=8, plainText[15:0]=0x0001.
